// File: rtl/enemy_wave_if.sv
// Sequencer-side bundle: frame/move/kill controls in, plotter drive and status out.
interface enemy_wave_if #(
  parameter int unsigned ROWS = 2,
  parameter int unsigned COLS = 4
);
  localparam int unsigned N = ROWS * COLS;

  logic         start;
  logic         move_tick;
  logic         kill_valid;
  logic [3:0]   kill_index;
  logic         enemy_done;
  logic         enemy_enable;
  logic [8:0]   x_pos_init;
  logic [7:0]   y_pos_init;
  logic         busy;
  logic         frame_done;
  logic [N-1:0] alive;
  logic         all_dead;
  logic         reached_bottom;

  // Sequencer view
  modport slave (
    input  start, move_tick, kill_valid, kill_index, enemy_done,
    output enemy_enable, x_pos_init, y_pos_init, busy, frame_done,
           alive, all_dead, reached_bottom
  );

  // Controller / plotter view
  modport master (
    output start, move_tick, kill_valid, kill_index, enemy_done,
    input  enemy_enable, x_pos_init, y_pos_init, busy, frame_done,
           alive, all_dead, reached_bottom
  );
endinterface

// File: rtl/enemy_wave_sequencer.sv
// Walks the enemy grid once per frame, feeding live enemy positions to the
// sprite plotter, then marches the formation and tracks the alive mask.
module enemy_wave_sequencer #(
  parameter int unsigned ROWS     = 2,
  parameter int unsigned COLS     = 4,
  parameter int unsigned X_STEP   = 40,
  parameter int unsigned Y_STEP   = 24,
  parameter int unsigned SPRITE_W = 28,
  parameter int unsigned SPRITE_H = 20,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned BOTTOM_Y = 200,
  parameter int unsigned X_INIT   = 16,
  parameter int unsigned Y_INIT   = 8,
  parameter int unsigned MOVE_DX  = 2,
  parameter int unsigned DROP_DY  = 8
) (
  input  logic         clk,
  input  logic         reset,
  enemy_wave_if.slave  bus
);

  localparam int unsigned N       = ROWS * COLS;
  localparam int unsigned IDX_W   = $clog2(N + 1);
  localparam int unsigned RIGHT_M = MOVE_DX + (COLS - 1) * X_STEP + SPRITE_W;
  localparam int unsigned BOT_M   = (ROWS - 1) * Y_STEP + SPRITE_H;

  typedef enum logic [1:0] {IDLE, SCAN, DRAW, MOVE} state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N-1:0]       alive_q, alive_d;
  logic [8:0]         grid_x_q, grid_x_d;
  logic [7:0]         grid_y_q, grid_y_d;
  logic               dir_left_q, dir_left_d;
  logic               move_pending_q;
  logic               enable_q;
  logic [8:0]         x_q;
  logic [7:0]         y_q;
  logic               busy_q;
  logic               frame_done_q;

  logic               slot_alive_c;
  int unsigned        row_c, col_c;
  logic [8:0]         slot_x_c;
  logic [7:0]         slot_y_c;

  // Alive bit and screen position of the slot under the scan index
  always_comb begin
    slot_alive_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) slot_alive_c = alive_q[i];
    end
    row_c    = 32'(idx_q) / COLS;
    col_c    = 32'(idx_q) % COLS;
    slot_x_c = 9'(32'(grid_x_q) + col_c * X_STEP);
    slot_y_c = 8'(32'(grid_y_q) + row_c * Y_STEP);
  end

  // Kill requests clear one alive bit; out-of-range indices match nothing
  always_comb begin
    alive_d = alive_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.kill_valid && (bus.kill_index == 4'(i))) alive_d[i] = 1'b0;
    end
  end

  // Formation step applied in MOVE: march, or reverse and drop at an edge
  always_comb begin
    grid_x_d   = grid_x_q;
    grid_y_d   = grid_y_q;
    dir_left_d = dir_left_q;
    if (move_pending_q) begin
      if (!dir_left_q && ((10'(grid_x_q) + 10'(RIGHT_M)) > 10'(SCREEN_W))) begin
        dir_left_d = 1'b1;
        grid_y_d   = grid_y_q + 8'(DROP_DY);
      end else if (dir_left_q && (10'(grid_x_q) < 10'(MOVE_DX))) begin
        dir_left_d = 1'b0;
        grid_y_d   = grid_y_q + 8'(DROP_DY);
      end else if (dir_left_q) begin
        grid_x_d = grid_x_q - 9'(MOVE_DX);
      end else begin
        grid_x_d = grid_x_q + 9'(MOVE_DX);
      end
    end
  end

  // Frame walk FSM with registered plotter drive and status
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      alive_q        <= '1;
      grid_x_q       <= 9'(X_INIT);
      grid_y_q       <= 8'(Y_INIT);
      dir_left_q     <= 1'b0;
      move_pending_q <= 1'b0;
      enable_q       <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q   <= 1'b0;
      alive_q        <= alive_d;
      move_pending_q <= move_pending_q | bus.move_tick;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (idx_q == IDX_W'(N)) begin
            state_q <= MOVE;
          end else if (!slot_alive_c) begin
            idx_q <= idx_q + IDX_W'(1);
          end else begin
            x_q      <= slot_x_c;
            y_q      <= slot_y_c;
            enable_q <= 1'b1;
            state_q  <= DRAW;
          end
        end
        DRAW: begin
          // Enable falls on the same edge the plotter leaves its done state
          if (bus.enemy_done) begin
            enable_q <= 1'b0;
            idx_q    <= idx_q + IDX_W'(1);
            state_q  <= SCAN;
          end
        end
        MOVE: begin
          grid_x_q       <= grid_x_d;
          grid_y_q       <= grid_y_d;
          dir_left_q     <= dir_left_d;
          move_pending_q <= bus.move_tick;
          frame_done_q   <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.enemy_enable   = enable_q;
  assign bus.x_pos_init     = x_q;
  assign bus.y_pos_init     = y_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.alive          = alive_q;
  assign bus.all_dead       = (alive_q == '0);
  assign bus.reached_bottom = (10'(grid_y_q) + 10'(BOT_M)) >= 10'(BOTTOM_Y);

endmodule

// File: tb/tb_enemy_wave_sequencer.sv
// Directed + randomized bench for enemy_wave_sequencer against a formation model.
module tb_enemy_wave_sequencer;

  logic clk;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  enemy_wave_if #(.ROWS(2), .COLS(4)) bus ();

  enemy_wave_sequencer #(.ROWS(2), .COLS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plotter: done reads 1 while idle, and plot_delay cycles after enable rises
  int plot_delay = 1;
  int plot_cnt   = 0;
  always @(posedge clk) begin
    if (!bus.enemy_enable) plot_cnt <= 0;
    else                   plot_cnt <= plot_cnt + 1;
  end
  assign bus.enemy_done = !bus.enemy_enable || (plot_cnt >= plot_delay);

  // Formation model: origin, direction, alive slots, pending move
  int         m_gx, m_gy;
  bit         m_left, m_pend;
  logic [7:0] m_alive;

  function automatic void m_reset();
    m_gx = 16; m_gy = 8; m_left = 1'b0; m_pend = 1'b0; m_alive = 8'hFF;
  endfunction

  function automatic void m_move();
    if (!m_pend) return;
    m_pend = 1'b0;
    // rightmost sprite edge after one more step, or leftmost step below zero
    if (!m_left && (m_gx + 2 + 3 * 40 + 28 > 320)) begin
      m_left = 1'b1; m_gy = (m_gy + 8) % 256;
    end else if (m_left && (m_gx < 2)) begin
      m_left = 1'b0; m_gy = (m_gy + 8) % 256;
    end else begin
      m_gx = m_left ? m_gx - 2 : m_gx + 2;
    end
  endfunction

  function automatic bit m_bottom();
    return (m_gy + 24 + 20) >= 200;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kill(input int i);
    bus.kill_valid = 1'b1; bus.kill_index = 4'(i);
    @(posedge clk); #1 bus.kill_valid = 1'b0;
    if (i < 8) m_alive = m_alive & ~(8'(1) << i);
  endtask

  task automatic tick();
    bus.move_tick = 1'b1;
    @(posedge clk); #1 bus.move_tick = 1'b0;
    m_pend = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    m_reset();
  endtask

  // One frame: start, observe draws, optional mid-frame events, compare to model
  task automatic run_frame(input int delay, input bit mid_kill, input bit mid_tick,
                           input bit mid_start, input bit mid_reset, output int n);
    int exp_q[$];
    int ox[$];
    int oy[$];
    int fd, px, py;
    bit prev_en, unstable, inj1, inj2;
    plot_delay = delay;
    for (int s = 0; s < 8; s++) if (m_alive[s]) exp_q.push_back(s);
    bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    n = 0; fd = 0; px = 0; py = 0;
    prev_en = 1'b0; unstable = 1'b0; inj1 = 1'b0; inj2 = 1'b0;
    while (fd == 0 && n < 20000) begin
      @(posedge clk); #1;
      n++;
      bus.kill_valid = 1'b0; bus.move_tick = 1'b0; bus.start = 1'b0;
      if (n == 1) chk("busy_in_frame", bus.busy, 1);
      if (bus.frame_done) fd++;
      if (bus.enemy_enable && !prev_en) begin
        px = int'(bus.x_pos_init); py = int'(bus.y_pos_init);
        ox.push_back(px); oy.push_back(py);
      end else if (bus.enemy_enable && prev_en &&
                   (int'(bus.x_pos_init) != px || int'(bus.y_pos_init) != py)) begin
        unstable = 1'b1;
      end
      prev_en = bus.enemy_enable;
      if (bus.enemy_enable && ox.size() == 1 && !inj1) begin
        inj1 = 1'b1;
        if (mid_kill && exp_q.size() >= 4) begin
          bus.kill_valid = 1'b1; bus.kill_index = 4'(exp_q[$]);
          m_alive = m_alive & ~(8'(1) << exp_q[$]);
          void'(exp_q.pop_back());
        end
      end
      if (bus.enemy_enable && ox.size() == 2 && !inj2) begin
        inj2 = 1'b1;
        if (mid_kill) begin
          bus.kill_valid = 1'b1; bus.kill_index = 4'(exp_q[1]);
          m_alive = m_alive & ~(8'(1) << exp_q[1]);
        end
        if (mid_tick) begin bus.move_tick = 1'b1; m_pend = 1'b1; end
        if (mid_start) bus.start = 1'b1;
      end
      if (mid_reset && ox.size() == 3) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        bus.kill_valid = 1'b0; bus.move_tick = 1'b0; bus.start = 1'b0;
        return;
      end
    end
    bus.kill_valid = 1'b0; bus.move_tick = 1'b0; bus.start = 1'b0;
    chk("frame_done_seen", fd, 1);
    chk("busy_at_frame_done", bus.busy, 0);
    chk("draw_count", ox.size(), exp_q.size());
    for (int k = 0; k < ox.size() && k < exp_q.size(); k++) begin
      chk("draw_x", ox[k], (m_gx + (exp_q[k] % 4) * 40) % 512);
      chk("draw_y", oy[k], (m_gy + (exp_q[k] / 4) * 24) % 256);
    end
    chk("pos_stable_in_draw", unstable, 0);
    m_move();
    @(posedge clk); #1;
    chk("frame_done_one_cycle", bus.frame_done, 0);
    chk("idle_after_frame", bus.busy, 0);
    chk("alive_mask", bus.alive, m_alive);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.move_tick = 1'b0; bus.kill_valid = 1'b0; bus.kill_index = 4'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_enable", bus.enemy_enable, 0);
    chk("rst_x", bus.x_pos_init, 0);
    chk("rst_y", bus.y_pos_init, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_alive", bus.alive, 8'hFF);
    chk("rst_all_dead", bus.all_dead, 0);
    chk("rst_bottom", bus.reached_bottom, 0);

    // Full grid, slow plotter
    run_frame(560, 1'b0, 1'b0, 1'b0, 1'b0, n);

    // Reset in the middle of the third draw
    run_frame(4, 1'b0, 1'b0, 1'b0, 1'b1, n);
    chk("midrst_enable", bus.enemy_enable, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_alive", bus.alive, 8'hFF);
    m_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_resume_busy", bus.busy, 0);
    chk("midrst_no_resume_en", bus.enemy_enable, 0);
    run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0, n);

    // Pre-frame kills, one out of range
    kill(1); kill(6); kill(9);
    chk("kill_mask", bus.alive, 8'b1011_1101);
    tick();
    run_frame(int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0, 1'b0, n);

    // Kill current and a future slot, tick and start while busy
    run_frame(int'($urandom_range(1, 6)), 1'b1, 1'b1, 1'b1, 1'b0, n);
    run_frame(int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0, 1'b0, n);

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) kill(int'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 1) tick();
      run_frame(int'($urandom_range(1, 6)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, n);
    end

    // March a single survivor across the screen until it reaches bottom
    do_reset();
    for (int s = 1; s < 8; s++) kill(s);
    chk("survivor_mask", bus.alive, 8'h01);
    for (int f = 0; f < 2500 && !m_bottom(); f++) begin
      tick();
      run_frame(1, 1'b0, 1'b0, 1'b0, 1'b0, n);
      chk("reached_bottom", bus.reached_bottom, m_bottom());
    end
    chk("bottom_final", bus.reached_bottom, 1);

    // Everything dead: scan all slots, move, no draws
    kill(0);
    chk("all_dead", bus.all_dead, 1);
    run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, n);
    chk("dead_frame_cycles", n, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
